// File: rtl/sprite_draw_scheduler_pkg.sv
// Shared types and widths for the sprite draw scheduler and its pixel mux.
package sprite_draw_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        WAIT_DONE = 3'd2,
        NEXT      = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int C_W   = 3;
    localparam int IDX_W = 4;

    localparam int DEFAULT_TIMEOUT_CYCLES = 32768;

endpackage

// File: rtl/sprite_draw_scheduler_pixel_client_mux.sv
// N-way select of one mover's pixel slice onto the VGA port; all zeros when not forwarding.
module pixel_client_mux
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int N_CLIENTS = 10
) (
    input  logic [IDX_W-1:0]           idx,
    input  logic                       fwd_en,
    input  logic [X_W*N_CLIENTS-1:0]   client_x,
    input  logic [Y_W*N_CLIENTS-1:0]   client_y,
    input  logic [C_W*N_CLIENTS-1:0]   client_colour,
    input  logic [N_CLIENTS-1:0]       client_plot,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [C_W-1:0]             vga_colour,
    output logic                       vga_plot
);

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (fwd_en && (idx == IDX_W'(i))) begin
                vga_x      = client_x[X_W*i +: X_W];
                vga_y      = client_y[Y_W*i +: Y_W];
                vga_colour = client_colour[C_W*i +: C_W];
                vga_plot   = client_plot[i];
            end
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Round-robin draw scheduler: grants movers 0..N-1 in turn and forwards the granted pixel stream.
// Optional per-grant watchdog enabled by defining SCHED_TIMEOUT_EN.
module sprite_draw_scheduler
    import sprite_draw_scheduler_pkg::*;
#(
    parameter int N_CLIENTS      = 10,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       run,
    output logic [N_CLIENTS-1:0]       client_en,
    input  logic [N_CLIENTS-1:0]       client_finish,
    input  logic [X_W*N_CLIENTS-1:0]   client_x,
    input  logic [Y_W*N_CLIENTS-1:0]   client_y,
    input  logic [C_W*N_CLIENTS-1:0]   client_colour,
    input  logic [N_CLIENTS-1:0]       client_plot,
    output logic [X_W-1:0]             vga_x,
    output logic [Y_W-1:0]             vga_y,
    output logic [C_W-1:0]             vga_colour,
    output logic                       vga_plot,
    output logic                       busy,
    output logic [IDX_W-1:0]           cur_idx,
    output logic                       round_done,
    output logic                       timeout_err,
    output logic [2:0]                 state_dbg
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLIENTS - 1);

    if (N_CLIENTS < 2 || N_CLIENTS > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("sprite_draw_scheduler: N_CLIENTS must be 2..16 and TIMEOUT_CYCLES >= 2");
    end

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       next_idx;
    logic [N_CLIENTS-1:0]   en_next;
    logic                   fin_sel;
    logic                   fwd_en;

    // Handshake: client_en is a one-cycle request to mover idx; that mover answers with a
    // one-cycle finish, which is only looked at in WAIT_DONE and only on bit idx.
    always_comb begin
        fin_sel = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (idx == IDX_W'(i)) fin_sel = client_finish[i];
        end
    end

    assign next_idx = (state == NEXT) ? idx + IDX_W'(1) : '0;

    always_comb begin
        en_next = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            en_next[i] = (next_idx == IDX_W'(i));
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             to_hit;
    assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            idx        <= '0;
            client_en  <= '0;
            busy       <= 1'b0;
            round_done <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            client_en  <= '0;
            round_done <= 1'b0;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (run) begin
                        state     <= GRANT;
                        client_en <= en_next;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    state <= WAIT_DONE;
`ifdef SCHED_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                WAIT_DONE: begin
                    // finish wins over a watchdog expiry in the same cycle
                    if (fin_sel) begin
                        state <= NEXT;
                    end
`ifdef SCHED_TIMEOUT_EN
                    else if (to_hit) begin
                        state       <= NEXT;
                        timeout_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
`endif
                end
                NEXT: begin
                    if (idx == LAST_IDX) begin
                        state      <= DONE;
                        round_done <= 1'b1;
                    end else begin
                        idx       <= next_idx;
                        state     <= GRANT;
                        client_en <= en_next;
                    end
                end
                DONE: begin
                    idx   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    idx   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fwd_en    = (state == GRANT) || (state == WAIT_DONE);
    assign cur_idx   = idx;
    assign state_dbg = state;

    pixel_client_mux #(
        .N_CLIENTS (N_CLIENTS)
    ) u_pixel_client_mux (
        .idx           (idx),
        .fwd_en        (fwd_en),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .client_plot   (client_plot),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot)
    );

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Randomized scoreboard bench for sprite_draw_scheduler with a round-level reference model.
`timescale 1ns/1ps
module tb_sprite_draw_scheduler;
    import sprite_draw_scheduler_pkg::*;

    localparam int N      = 3;
    localparam int TO     = 16;
    localparam int CYCLES = 2500;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             resetn;
    logic             run;
    logic [N-1:0]     client_en;
    logic [N-1:0]     client_finish;
    logic [8*N-1:0]   client_x;
    logic [7*N-1:0]   client_y;
    logic [3*N-1:0]   client_colour;
    logic [N-1:0]     client_plot;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       vga_colour;
    logic             vga_plot;
    logic             busy;
    logic [3:0]       cur_idx;
    logic             round_done;
    logic             timeout_err;
    logic [2:0]       state_dbg;

    always #5 clk = ~clk;

    sprite_draw_scheduler #(
        .N_CLIENTS      (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .run           (run),
        .client_en     (client_en),
        .client_finish (client_finish),
        .client_x      (client_x),
        .client_y      (client_y),
        .client_colour (client_colour),
        .client_plot   (client_plot),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour),
        .vga_plot      (vga_plot),
        .busy          (busy),
        .cur_idx       (cur_idx),
        .round_done    (round_done),
        .timeout_err   (timeout_err),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int         cyc;
        logic       busy;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       plot;
        logic [3:0] cur;
        logic       terr;
    } cyc_exp_t;

    typedef struct {
        int           cyc;
        logic [N-1:0] en;
        logic         rd;
    } ev_exp_t;

    cyc_exp_t cyc_q[$];
    ev_exp_t  ev_q[$];
    int       n_vec = 0;
    int       n_err = 0;
    int       cyc   = -1;
    bit       mon_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // monitor: every cycle consumes the per-cycle expectation; grant/done events pop the event queue
    always @(negedge clk) begin
        cyc_exp_t     e;
        ev_exp_t      v;
        logic [N-1:0] een;
        logic         erd;
        if (mon_on) begin
            if (cyc_q.size() == 0 || cyc_q[0].cyc != cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_sync cycle %0d: no expectation queued for this cycle", cyc);
            end else begin
                e = cyc_q.pop_front();
                check("busy",        32'(busy),        32'(e.busy));
                check("vga_x",       32'(vga_x),       32'(e.x));
                check("vga_y",       32'(vga_y),       32'(e.y));
                check("vga_colour",  32'(vga_colour),  32'(e.col));
                check("vga_plot",    32'(vga_plot),    32'(e.plot));
                check("cur_idx",     32'(cur_idx),     32'(e.cur));
                check("timeout_err", 32'(timeout_err), 32'(e.terr));
            end
            een = '0;
            erd = 1'b0;
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                v = ev_q.pop_front();
                n_vec++;
                n_err++;
                $display("FAIL missed_event cycle %0d: event for cycle %0d never matched", cyc, v.cyc);
            end
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                v   = ev_q.pop_front();
                een = v.en;
                erd = v.rd;
            end
            check("client_en",  32'(client_en),  32'(een));
            check("round_done", 32'(round_done), 32'(erd));
        end
    end

    // ---------------- reference model state (round level) ----------------
    bit           rst_now;
    bit           leave;
    bit           m_idle  = 1'b1;
    bit           m_active = 1'b0;
    bit           m_terr  = 1'b0;
    int           owner   = 0;
    int           m_g     = 0;
    int           fin_at  = -1;
    int           pend_g  = -1;
    int           pend_i  = 0;
    int           idle_at = -1;
    int           m_cur   = 0;
    int           rounds  = 0;
    logic [N-1:0] oh;
    cyc_exp_t     ce;

    task automatic drive_pixels();
        for (int i = 0; i < N; i++) begin
            client_x[8*i +: 8]      = 8'($urandom);
            client_y[7*i +: 7]      = 7'($urandom);
            client_colour[3*i +: 3] = 3'($urandom);
            client_plot[i]          = 1'($urandom_range(0, 1));
        end
    endtask

    // ---------------- stimulus + model ----------------
    initial begin
        resetn        = 1'b0;
        run           = 1'b1;
        client_finish = '0;
        client_x      = '0;
        client_y      = '0;
        client_colour = '0;
        client_plot   = '0;

        for (int c = 0; c < CYCLES; c++) begin
            @(posedge clk);
            #1;
            cyc     = c;
            rst_now = (c < 3) || (c >= 1500 && c < 1502);
            resetn  = !rst_now;
            if (c >= 800 && c < 900) run = 1'b0;
            else                     run = ($urandom_range(0, 99) < 80);

            if (idle_at == c) begin
                m_idle  = 1'b1;
                m_cur   = 0;
                idle_at = -1;
            end
            if (pend_g == c) begin
                owner    = pend_i;
                m_g      = c;
                m_active = 1'b1;
                m_cur    = pend_i;
                pend_g   = -1;
                if (owner == 0) rounds++;
                fin_at = c + $urandom_range(2, 7);
`ifdef SCHED_TIMEOUT_EN
                if (rounds == 2 && owner == 1) fin_at = c + TO;
                if (rounds == 4 && owner == 0) fin_at = -1;
`endif
            end

            drive_pixels();
            if (m_active && owner == 1 && rounds == 1) begin
                client_x[8*1 +: 8]      = 8'd30;
                client_y[7*1 +: 7]      = 7'd28;
                client_colour[3*1 +: 3] = 3'b101;
                client_plot[1]          = 1'b1;
                client_x[8*0 +: 8]      = 8'd200;
                client_y[7*0 +: 7]      = 7'd99;
                client_colour[3*0 +: 3] = 3'b010;
                client_plot[0]          = 1'b1;
            end

            client_finish = '0;
            if (m_active && c == fin_at) client_finish[owner] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (!(m_active && i == owner && c > m_g) && $urandom_range(0, 7) == 0)
                    client_finish[i] = 1'b1;
            end

            ce.cyc  = c;
            ce.busy = !m_idle;
            ce.cur  = 4'(m_cur);
            ce.terr = m_terr;
            if (m_active) begin
                ce.x    = client_x[8*owner +: 8];
                ce.y    = client_y[7*owner +: 7];
                ce.col  = client_colour[3*owner +: 3];
                ce.plot = client_plot[owner];
            end else begin
                ce.x    = '0;
                ce.y    = '0;
                ce.col  = '0;
                ce.plot = 1'b0;
            end
            cyc_q.push_back(ce);

            leave = 1'b0;
            if (m_active && c > m_g) begin
                if (client_finish[owner]) leave = 1'b1;
`ifdef SCHED_TIMEOUT_EN
                else if (c == m_g + TO) begin
                    leave  = 1'b1;
                    m_terr = 1'b1;
                end
`endif
            end
            if (leave) begin
                m_active = 1'b0;
                if (owner == N - 1) begin
                    ev_q.push_back('{c + 2, '0, 1'b1});
                    idle_at = c + 3;
                end else begin
                    oh = '0;
                    oh[owner + 1] = 1'b1;
                    ev_q.push_back('{c + 2, oh, 1'b0});
                    pend_g = c + 2;
                    pend_i = owner + 1;
                end
            end
            if (m_idle && run && !rst_now) begin
                oh = '0;
                oh[0] = 1'b1;
                ev_q.push_back('{c + 1, oh, 1'b0});
                pend_g = c + 1;
                pend_i = 0;
                m_idle = 1'b0;
            end
            if (rst_now) begin
                m_idle   = 1'b1;
                m_active = 1'b0;
                m_terr   = 1'b0;
                pend_g   = -1;
                idle_at  = -1;
                m_cur    = 0;
                while (ev_q.size() > 0 && ev_q[ev_q.size() - 1].cyc > c) void'(ev_q.pop_back());
            end
            mon_on = 1'b1;
        end

        @(negedge clk);
        #1;
        mon_on = 1'b0;
        foreach (ev_q[i]) begin
            if (ev_q[i].cyc < CYCLES) begin
                n_vec++;
                n_err++;
                $display("FAIL unmatched_event: event for cycle %0d left in queue", ev_q[i].cyc);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
